// File: rtl/mem_map_pkg.sv
// Shared definitions for the M-stage bus controller: system address map
// windows, timer COUNT register addresses, req_op encodings and FSM states.
package mem_map_pkg;

  // Address windows (inclusive limits).
  localparam logic [31:0] DM_BASE    = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT   = 32'h0000_2fff;
  localparam logic [31:0] TMR0_BASE  = 32'h0000_7f00;
  localparam logic [31:0] TMR0_LIMIT = 32'h0000_7f0b;
  localparam logic [31:0] TMR1_BASE  = 32'h0000_7f10;
  localparam logic [31:0] TMR1_LIMIT = 32'h0000_7f1b;
  localparam logic [31:0] IRQ_BASE   = 32'h0000_7f20;
  localparam logic [31:0] IRQ_LIMIT  = 32'h0000_7f23;

  // Timer COUNT registers are read-only.
  localparam logic [31:0] TMR0_COUNT = 32'h0000_7f08;
  localparam logic [31:0] TMR1_COUNT = 32'h0000_7f18;

  // req_op encodings (stores reuse them: 001/010 sb, 011/100 sh).
  localparam logic [2:0] OP_WORD  = 3'b000;
  localparam logic [2:0] OP_UBYTE = 3'b001;
  localparam logic [2:0] OP_SBYTE = 3'b010;
  localparam logic [2:0] OP_UHALF = 3'b011;
  localparam logic [2:0] OP_SHALF = 3'b100;

  // Controller FSM states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic in_win(input logic [31:0] a,
                                  input logic [31:0] base,
                                  input logic [31:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data alignment: picks the byte/halfword addressed by byte_off out of
// the bus word and zero/sign-extends it according to op.
//   op       in  3   req_op encoding of the load
//   byte_off in  2   low address bits of the load
//   word     in  32  raw bus read word
//   data     out 32  right-aligned, extended load result
module mem_load_ext
  import mem_map_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_UBYTE: data = {24'h000000, byte_sel};
      OP_SBYTE: data = {{24{byte_sel[7]}}, byte_sel};
      OP_UHALF: data = {16'h0000, half_sel};
      OP_SHALF: data = {{16{half_sel[15]}}, half_sel};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// M-stage load/store sequencer for the shared system bus.
// Checks legality, drives lane enables and replicated store data, waits for a
// variable-latency bus_ack (with timeout) and returns extended load data or
// an AdEL/AdES exception.
//   clk, reset              clock, async active-low reset
//   req_*                   M-stage request (valid, we, op, addr, ovf, wdata, flush)
//   stall                   hold M stage and earlier
//   resp_valid/resp_rdata   one-cycle completion pulse, extended load data
//   exc_adel/exc_ades       load/store address exception, valid with resp_valid
//   bus_*                   system bus master side
//   dbg_state               current FSM state
//
// Handshake: a request is taken when req_valid=1 in IDLE; the CPU keeps the
// request stable while stall=1, and the access ends with a single-cycle
// resp_valid in DONE (where stall is 0). On the bus, bus_req/addr/we/byteen/
// wdata stay constant while in BUSY and the transfer ends on the cycle
// bus_ack=1; bus_ack at any other time is ignored.
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic        req_ovf,
  input  logic [31:0] req_wdata,
  input  logic        req_flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [2:0]       op_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             exc_q;
  logic             kill_q;

  // Legality of the incoming request.
  logic is_word, is_half, is_byte, in_dm, in_tmr, in_irq, is_count, illegal;

  always_comb begin
    is_word  = (req_op == OP_WORD);
    is_byte  = (req_op == OP_UBYTE) || (req_op == OP_SBYTE);
    is_half  = (req_op == OP_UHALF) || (req_op == OP_SHALF);
    in_dm    = in_win(req_addr, DM_BASE, DM_LIMIT);
    in_tmr   = in_win(req_addr, TMR0_BASE, TMR0_LIMIT) ||
               in_win(req_addr, TMR1_BASE, TMR1_LIMIT);
    in_irq   = in_win(req_addr, IRQ_BASE, IRQ_LIMIT);
    is_count = (req_addr == TMR0_COUNT) || (req_addr == TMR1_COUNT);
    illegal  = req_ovf
             | (req_op > OP_SHALF)
             | (is_word & (req_addr[1:0] != 2'b00))
             | (is_half & req_addr[0])
             | ((is_byte | is_half) & in_tmr)   // timers are word-only
             | ~(in_dm | in_tmr | in_irq)
             | (req_we & is_count);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q  <= '0;
          exc_q  <= 1'b0;
          kill_q <= 1'b0;
          if (req_valid && !req_flush) begin
            addr_q  <= req_addr;
            op_q    <= req_op;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            if (illegal) begin
              exc_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // A flush cannot abort the bus cycle; it only hides the response.
          if (req_flush) kill_q <= 1'b1;
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            state_q <= ST_DONE;
          end else if (cnt_q == TERM_CNT) begin
            exc_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Lane enables and replicated store data from the latched request.
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;

  always_comb begin
    lane_be = 4'b0000;
    lane_wd = '0;
    case (op_q)
      OP_WORD: begin
        lane_be = 4'b1111;
        lane_wd = wdata_q;
      end
      OP_UBYTE, OP_SBYTE: begin
        lane_be = 4'b0001 << addr_q[1:0];
        lane_wd = {4{wdata_q[7:0]}};
      end
      OP_UHALF, OP_SHALF: begin
        lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_be = 4'b0000;
        lane_wd = '0;
      end
    endcase
  end

  logic [31:0] ext_data;

  mem_load_ext u_load_ext (
    .op       (op_q),
    .byte_off (addr_q[1:0]),
    .word     (rdata_q),
    .data     (ext_data)
  );

  logic busy, done, resp_ok;

  assign busy    = (state_q == ST_BUSY);
  assign done    = (state_q == ST_DONE);
  assign resp_ok = done & ~kill_q & ~req_flush;

  assign stall      = ((state_q == ST_IDLE) & req_valid) | busy;
  assign resp_valid = resp_ok;
  assign exc_adel   = resp_ok & exc_q & ~we_q;
  assign exc_ades   = resp_ok & exc_q & we_q;
  assign resp_rdata = (resp_ok & ~we_q & ~exc_q) ? ext_data : '0;

  assign bus_req    = busy;
  assign bus_we     = busy & we_q;
  assign bus_addr   = busy ? {addr_q[31:2], 2'b00} : '0;
  assign bus_byteen = (busy & we_q) ? lane_be : 4'b0000;
  assign bus_wdata  = (busy & we_q) ? lane_wd : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
  import mem_map_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic        req_ovf;
  logic [31:0] req_wdata;
  logic        req_flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last do_access call.
  int          r_lat;
  logic [31:0] r_rdata;
  logic        r_adel, r_ades, r_saw_req, r_bwe, r_ended, r_stall0;
  logic [3:0]  r_be;
  logic [31:0] r_wd, r_addr;

  mem_bus_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_ovf    (req_ovf),
    .req_wdata  (req_wdata),
    .req_flush  (req_flush),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_byteen (bus_byteen),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one access. Cycle 0 is the request cycle; r_lat is the cycle
  // index where resp_valid was seen (-1 if never). ack_wait is the number of
  // BUSY cycles without ack before acking (-1 = never ack). flush_at pulses
  // req_flush in that cycle (0 = no flush).
  task automatic do_access(input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic ovf,
                           input logic [31:0] wd, input int ack_wait,
                           input logic [31:0] rd, input int flush_at);
    int nb;
    nb = 0;
    r_lat = -1; r_rdata = '0; r_adel = 0; r_ades = 0; r_saw_req = 0;
    r_bwe = 0; r_ended = 0; r_be = '0; r_wd = '0; r_addr = '0;
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr;
    req_ovf = ovf; req_wdata = wd; req_flush = 1'b0;
    #1 r_stall0 = stall;
    @(posedge clk); #1;
    for (int c = 1; c <= 40 && !r_ended; c++) begin
      if (resp_valid) begin
        r_lat = c; r_rdata = resp_rdata; r_adel = exc_adel; r_ades = exc_ades;
      end
      if (bus_req) begin
        r_saw_req = 1'b1; r_be = bus_byteen; r_wd = bus_wdata;
        r_addr = bus_addr; r_bwe = bus_we;
        bus_ack   = (nb == ack_wait);
        bus_rdata = (nb == ack_wait) ? rd : 32'hDEAD_DEAD;
        nb++;
      end else begin
        bus_ack = 1'b0; bus_rdata = 32'hDEAD_DEAD;
      end
      if (dbg_state == ST_DONE) begin
        r_ended = 1'b1; req_valid = 1'b0;
      end
      req_flush = (c == flush_at);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0; req_valid = 1'b0; req_flush = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 0; req_we = 0; req_op = 0; req_addr = 0;
    req_ovf = 0; req_wdata = 0; req_flush = 0; bus_ack = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({stall, resp_valid, exc_adel, exc_ades, bus_req, bus_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {stall, resp_valid, exc_adel, exc_ades, bus_req, bus_we});
    end
    n_checks++;
    if ({resp_rdata, bus_addr, bus_wdata, bus_byteen} !== 100'b0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h/%b expected zeros",
                         resp_rdata, bus_addr, bus_wdata, bus_byteen);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word;
    do_access(1'b0, OP_WORD, 32'h0000_0004, 1'b0, 32'h0, 3, 32'h89AB_CDEF, 0);
    n_checks++;
    if (r_stall0 !== 1'b1) begin
      n_fail++; $display("FAIL lw_stall_idle: got %b expected 1", r_stall0);
    end
    n_checks++;
    if (r_lat !== 5) begin
      n_fail++; $display("FAIL lw_latency: got %0d expected 5", r_lat);
    end
    n_checks++;
    if (r_rdata !== 32'h89AB_CDEF) begin
      n_fail++; $display("FAIL lw_rdata: got %h expected 89abcdef", r_rdata);
    end
    n_checks++;
    if ({r_addr, r_be, r_bwe, r_adel} !== {32'h0000_0004, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL lw_bus: got addr %h be %b we %b adel %b expected 00000004/0000/0/0",
                         r_addr, r_be, r_bwe, r_adel);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] exp;
  } ld_vec_t;

  task automatic test_load_ext;
    ld_vec_t v[8];
    v[0] = '{OP_SBYTE, 32'h0000_0007, 32'h80FF_0000, 32'hFFFF_FF80};
    v[1] = '{OP_UBYTE, 32'h0000_0007, 32'h80FF_0000, 32'h0000_0080};
    v[2] = '{OP_SHALF, 32'h0000_0006, 32'h80FF_0000, 32'hFFFF_80FF};
    v[3] = '{OP_UHALF, 32'h0000_0004, 32'h1234_F00D, 32'h0000_F00D};
    v[4] = '{OP_SHALF, 32'h0000_0004, 32'h1234_F00D, 32'hFFFF_F00D};
    v[5] = '{OP_SBYTE, 32'h0000_0005, 32'h1234_F00D, 32'hFFFF_FFF0};
    v[6] = '{OP_UBYTE, 32'h0000_7f23, 32'hAB00_0000, 32'h0000_00AB};
    v[7] = '{OP_WORD,  32'h0000_2ffc, 32'hCAFE_F00D, 32'hCAFE_F00D};
    for (int i = 0; i < 8; i++) begin
      do_access(1'b0, v[i].op, v[i].addr, 1'b0, 32'h0, 0, v[i].rd, 0);
      n_checks++;
      if (r_rdata !== v[i].exp || r_lat !== 2 || r_adel !== 1'b0) begin
        n_fail++; $display("FAIL load_ext[%0d]: got data %h lat %0d adel %b expected %h/2/0",
                           i, r_rdata, r_lat, r_adel, v[i].exp);
      end
    end
  endtask

  task automatic test_store;
    do_access(1'b1, OP_UBYTE, 32'h0000_0102, 1'b0, 32'h0000_00A5, 0, 32'h0, 0);
    n_checks++;
    if ({r_be, r_wd, r_addr, r_bwe} !== {4'b0100, 32'hA5A5_A5A5, 32'h0000_0100, 1'b1}) begin
      n_fail++; $display("FAIL sb_bus: got be %b wd %h addr %h we %b expected 0100/a5a5a5a5/00000100/1",
                         r_be, r_wd, r_addr, r_bwe);
    end
    n_checks++;
    if (r_lat !== 2 || r_ades !== 1'b0) begin
      n_fail++; $display("FAIL sb_resp: got lat %0d ades %b expected 2/0", r_lat, r_ades);
    end
    do_access(1'b1, OP_SHALF, 32'h0000_0006, 1'b0, 32'h1234_BEEF, 1, 32'h0, 0);
    n_checks++;
    if ({r_be, r_wd, r_lat} !== {4'b1100, 32'hBEEF_BEEF, 32'd3}) begin
      n_fail++; $display("FAIL sh_bus: got be %b wd %h lat %0d expected 1100/beefbeef/3",
                         r_be, r_wd, r_lat);
    end
    do_access(1'b1, OP_UHALF, 32'h0000_0010, 1'b0, 32'h0000_1357, 0, 32'h0, 0);
    n_checks++;
    if ({r_be, r_wd} !== {4'b0011, 32'h1357_1357}) begin
      n_fail++; $display("FAIL sh_low_bus: got be %b wd %h expected 0011/13571357", r_be, r_wd);
    end
    do_access(1'b1, OP_WORD, 32'h0000_7f04, 1'b0, 32'hDEAD_BEEF, 0, 32'h0, 0);
    n_checks++;
    if ({r_be, r_wd, r_addr, r_ades} !== {4'b1111, 32'hDEAD_BEEF, 32'h0000_7f04, 1'b0}) begin
      n_fail++; $display("FAIL sw_timer_bus: got be %b wd %h addr %h ades %b expected 1111/deadbeef/00007f04/0",
                         r_be, r_wd, r_addr, r_ades);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        ovf;
  } bad_vec_t;

  task automatic test_illegal;
    bad_vec_t v[8];
    v[0] = '{1'b1, OP_UHALF, 32'h0000_7f00, 1'b0};  // sh to timer
    v[1] = '{1'b0, OP_WORD,  32'h0000_0002, 1'b0};  // misaligned lw
    v[2] = '{1'b0, OP_WORD,  32'h0000_3000, 1'b0};  // just past DM
    v[3] = '{1'b1, OP_WORD,  32'h0000_7f08, 1'b0};  // sw timer0 COUNT
    v[4] = '{1'b0, OP_WORD,  32'h0000_0000, 1'b1};  // address overflow
    v[5] = '{1'b0, OP_WORD,  32'h0000_7f0c, 1'b0};  // gap between timers
    v[6] = '{1'b0, 3'b101,   32'h0000_0000, 1'b0};  // reserved op
    v[7] = '{1'b1, OP_WORD,  32'h0000_7f18, 1'b0};  // sw timer1 COUNT
    for (int i = 0; i < 8; i++) begin
      do_access(v[i].we, v[i].op, v[i].addr, v[i].ovf, 32'h0, 0, 32'h0, 0);
      n_checks++;
      if (r_saw_req !== 1'b0 || r_lat !== 1 || r_adel !== ~v[i].we || r_ades !== v[i].we) begin
        n_fail++; $display("FAIL illegal[%0d]: got req %b lat %0d adel %b ades %b expected 0/1/%b/%b",
                           i, r_saw_req, r_lat, r_adel, r_ades, ~v[i].we, v[i].we);
      end
    end
  endtask

  task automatic test_timeout;
    do_access(1'b0, OP_WORD, 32'h0000_7f20, 1'b0, 32'h0, -1, 32'h0, 0);
    n_checks++;
    if (r_lat !== 17 || r_adel !== 1'b1 || r_saw_req !== 1'b1) begin
      n_fail++; $display("FAIL timeout: got lat %0d adel %b req %b expected 17/1/1",
                         r_lat, r_adel, r_saw_req);
    end
    do_access(1'b0, OP_WORD, 32'h0000_7f20, 1'b0, 32'h0, 15, 32'h0000_00C3, 0);
    n_checks++;
    if (r_lat !== 17 || r_adel !== 1'b0 || r_rdata !== 32'h0000_00C3) begin
      n_fail++; $display("FAIL ack_at_terminal: got lat %0d adel %b data %h expected 17/0/000000c3",
                         r_lat, r_adel, r_rdata);
    end
    do_access(1'b1, OP_WORD, 32'h0000_0040, 1'b0, 32'h1, -1, 32'h0, 0);
    n_checks++;
    if (r_lat !== 17 || r_ades !== 1'b1 || r_adel !== 1'b0) begin
      n_fail++; $display("FAIL store_timeout: got lat %0d ades %b adel %b expected 17/1/0",
                         r_lat, r_ades, r_adel);
    end
  endtask

  task automatic test_flush_busy;
    do_access(1'b0, OP_WORD, 32'h0000_0010, 1'b0, 32'h0, 2, 32'h1111_2222, 1);
    n_checks++;
    if (r_ended !== 1'b1 || r_saw_req !== 1'b1 || r_lat !== -1) begin
      n_fail++; $display("FAIL flush_busy: got ended %b req %b lat %0d expected 1/1/-1",
                         r_ended, r_saw_req, r_lat);
    end
  endtask

  task automatic test_back_to_back;
    // Follows the flushed access: the kill must not leak into this one.
    do_access(1'b0, OP_WORD, 32'h0000_0014, 1'b0, 32'h0, 0, 32'h55AA_55AA, 0);
    n_checks++;
    if (r_lat !== 2 || r_rdata !== 32'h55AA_55AA) begin
      n_fail++; $display("FAIL b2b_after_flush: got lat %0d data %h expected 2/55aa55aa",
                         r_lat, r_rdata);
    end
  endtask

  task automatic test_reset_mid_busy;
    req_valid = 1'b1; req_we = 1'b0; req_op = OP_WORD; req_addr = 32'h0000_0020;
    req_ovf = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++; $display("FAIL busy_before_reset: got %b expected 1", bus_req);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_busy: got req %b addr %h expected 0/00000000",
                         bus_req, bus_addr);
    end
    req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dbg_state !== ST_IDLE || stall !== 1'b0) begin
      n_fail++; $display("FAIL after_reset: got state %0d stall %b expected 0/0", dbg_state, stall);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_illegal();
    test_timeout();
    test_flush_busy();
    test_back_to_back();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
